ioctl_upload_server: RTL and testbench

- Serves the host-side ioctl upload path, the read direction of the download interface into `system`: host reads bytes out of core memory, e.g. save RAM or a memory dump.
- Sits in `emu` alongside the download wiring.
- Decodes `ioctl_rd` strobes, arbitrates a byte read on a shared memory port with a req/ack handshake, and holds `ioctl_wait` until data is valid.
- Out-of-range addresses, index mismatch and memory timeouts return a fill byte, so the host never hangs.

---
 rtl/ioctl_upload_server.sv | 180 ++++++++++++++++++
 tb/tb_ioctl_upload_server.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_upload_server.sv
// ioctl_upload_server
//
// Host-side upload (read) path of the ioctl download interface. The host
// issues single-cycle ioctl_rd strobes; this block forwards in-range reads
// for its own ioctl_index to a shared memory port with a level req / one-
// cycle ack handshake, holds ioctl_wait until the byte is valid, and answers
// everything it cannot serve (wrong index, out-of-range address, memory
// timeout) with the FILL byte so the host never stalls.
//
// Ports:
//   clk_sys        system clock
//   reset_n        asynchronous active-low reset
//   ioctl_upload   upload session active (level)
//   ioctl_rd       single-cycle read strobe
//   ioctl_addr     25-bit byte address of the read
//   ioctl_index    target selector
//   ioctl_din      read data returned to the host
//   ioctl_wait     high while a read is outstanding
//   mem_req        memory read request, held until ack or abort
//   mem_addr       memory read address, constant while mem_req is high
//   mem_ack        one-cycle ack, mem_data valid in the same cycle
//   mem_data       memory read data
//   upload_active  registered ioctl_upload, used to hold the core off the bus
//   upload_count   bytes served this session, saturating
//   upload_err     sticky memory-timeout flag, cleared on a new session

module ioctl_upload_server #(
    parameter int         AW      = 17,
    parameter int         SIZE    = 131072,
    parameter logic [7:0] INDEX   = 8'd4,
    parameter logic [7:0] FILL    = 8'hFF,
    parameter int         TIMEOUT = 255
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_index,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [7:0]    mem_data,
    output logic          upload_active,
    output logic [AW:0]   upload_count,
    output logic          upload_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The timeout fires on the REQ cycle in which the counter would reach
    // TIMEOUT, so a read that is never acked spends exactly TIMEOUT cycles
    // in REQ.
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] SIZE_W       = 32'(SIZE);
    localparam logic [AW:0] COUNT_MAX    = {(AW+1){1'b1}};
    localparam logic [AW:0] COUNT_ONE    = {{AW{1'b0}}, 1'b1};

    state_t        state, state_nx;
    logic [7:0]    tcnt, tcnt_nx;
    logic [7:0]    din_nx;
    logic          wait_nx;
    logic          req_nx;
    logic [AW-1:0] addr_nx;
    logic [AW:0]   count_nx;
    logic          err_nx;

    logic          session_start;
    logic          addr_hit;
    logic          count_inc;
    logic [AW:0]   count_base;

    // A session starts on the edge where upload_active goes 0 -> 1. A fill
    // read sampled on that same edge counts as the first byte of the new
    // session rather than being lost to the clear.
    assign session_start = ioctl_upload & ~upload_active;
    assign count_base    = session_start ? '0 : upload_count;

    // Full 25-bit compare: address bits above AW make the read out of range.
    assign addr_hit = ({7'd0, ioctl_addr} < SIZE_W);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            tcnt          <= '0;
            ioctl_din     <= FILL;
            ioctl_wait    <= 1'b0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            upload_active <= 1'b0;
            upload_count  <= '0;
            upload_err    <= 1'b0;
        end else begin
            state         <= state_nx;
            tcnt          <= tcnt_nx;
            ioctl_din     <= din_nx;
            ioctl_wait    <= wait_nx;
            mem_req       <= req_nx;
            mem_addr      <= addr_nx;
            upload_active <= ioctl_upload;
            upload_count  <= count_nx;
            upload_err    <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        tcnt_nx   = tcnt;
        din_nx    = ioctl_din;
        wait_nx   = ioctl_wait;
        req_nx    = mem_req;
        addr_nx   = mem_addr;
        err_nx    = session_start ? 1'b0 : upload_err;
        count_inc = 1'b0;

        case (state)
            IDLE: begin
                if (ioctl_rd && ioctl_upload) begin
                    if ((ioctl_index == INDEX) && addr_hit) begin
                        addr_nx  = ioctl_addr[AW-1:0];
                        req_nx   = 1'b1;
                        wait_nx  = 1'b1;
                        tcnt_nx  = '0;
                        state_nx = REQ;
                    end else begin
                        din_nx    = FILL;
                        count_inc = 1'b1;
                    end
                end
            end

            REQ: begin
                // Abort leaves ioctl_din and upload_count untouched; a late
                // ack then lands in IDLE where it is ignored.
                if (!ioctl_upload) begin
                    req_nx   = 1'b0;
                    wait_nx  = 1'b0;
                    state_nx = IDLE;
                end else if (mem_ack) begin
                    din_nx    = mem_data;
                    req_nx    = 1'b0;
                    wait_nx   = 1'b0;
                    count_inc = 1'b1;
                    state_nx  = DONE;
                end else if (tcnt == TIMEOUT_LAST) begin
                    din_nx    = FILL;
                    req_nx    = 1'b0;
                    wait_nx   = 1'b0;
                    err_nx    = 1'b1;
                    count_inc = 1'b1;
                    state_nx  = DONE;
                end else begin
                    tcnt_nx = tcnt + 8'd1;
                end
            end

            DONE: begin
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
                req_nx   = 1'b0;
                wait_nx  = 1'b0;
            end
        endcase

        count_nx = count_base;
        if (count_inc && (count_base != COUNT_MAX)) begin
            count_nx = count_base + COUNT_ONE;
        end
    end

endmodule

// File: tb/tb_ioctl_upload_server.sv
// tb_ioctl_upload_server
//
// Self-checking bench for ioctl_upload_server. A host/memory driver issues
// reads with a chosen ack delay; expected results come from a transaction
// level model (served reads return the memory byte or FILL on timeout,
// everything else returns FILL; every answered read counts one byte). A
// second, narrow instance shares the inputs to exercise count saturation.

module tb_ioctl_upload_server;

    localparam int         AW      = 17;
    localparam int         SIZE    = 131072;
    localparam logic [7:0] INDEX   = 8'd4;
    localparam logic [7:0] FILL    = 8'hFF;
    localparam int         TIMEOUT = 255;

    logic          clk;
    logic          reset_n;
    logic          ioctl_upload;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_index;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [7:0]    mem_data;
    logic          upload_active;
    logic [AW:0]   upload_count;
    logic          upload_err;

    logic [7:0]    s_din;
    logic          s_wait;
    logic          s_req;
    logic [2:0]    s_addr;
    logic          s_active;
    logic [3:0]    s_count;
    logic          s_err;

    int vectors;
    int miscompares;

    int         exp_count;
    bit         exp_err;
    logic [7:0] exp_din;

    ioctl_upload_server #(
        .AW(AW), .SIZE(SIZE), .INDEX(INDEX), .FILL(FILL), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_sys       (clk),
        .reset_n       (reset_n),
        .ioctl_upload  (ioctl_upload),
        .ioctl_rd      (ioctl_rd),
        .ioctl_addr    (ioctl_addr),
        .ioctl_index   (ioctl_index),
        .ioctl_din     (ioctl_din),
        .ioctl_wait    (ioctl_wait),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .upload_active (upload_active),
        .upload_count  (upload_count),
        .upload_err    (upload_err)
    );

    ioctl_upload_server #(
        .AW(3), .SIZE(8), .INDEX(INDEX), .FILL(FILL), .TIMEOUT(TIMEOUT)
    ) dut_small (
        .clk_sys       (clk),
        .reset_n       (reset_n),
        .ioctl_upload  (ioctl_upload),
        .ioctl_rd      (ioctl_rd),
        .ioctl_addr    (ioctl_addr),
        .ioctl_index   (ioctl_index),
        .ioctl_din     (s_din),
        .ioctl_wait    (s_wait),
        .mem_req       (s_req),
        .mem_addr      (s_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .upload_active (s_active),
        .upload_count  (s_count),
        .upload_err    (s_err)
    );

    // 100 MHz system clock; outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host read with the memory acking in REQ cycle ack_delay (0 = first
    // REQ cycle, negative = never). Optionally strobes a second rd while
    // ioctl_wait is high. Returns what the host saw.
    task automatic read_txn(input logic [24:0] addr, input logic [7:0] idx,
                            input int ack_delay, input logic [7:0] data,
                            input bit inject,
                            output logic [7:0] din, output int wait_cycles,
                            output bit req_seen, output bit addr_ok);
        int n;
        @(negedge clk);
        ioctl_rd    = 1'b1;
        ioctl_addr  = addr;
        ioctl_index = idx;
        @(negedge clk);
        ioctl_rd    = 1'b0;
        ioctl_addr  = 25'($urandom);
        wait_cycles = 0;
        req_seen    = mem_req;
        addr_ok     = 1'b1;
        n           = 0;
        while (ioctl_wait && n < 400) begin
            wait_cycles++;
            if (mem_req) begin
                req_seen = 1'b1;
                if (mem_addr !== addr[AW-1:0]) addr_ok = 1'b0;
            end
            mem_ack  = (n == ack_delay);
            mem_data = mem_ack ? data : 8'($urandom);
            ioctl_rd = inject && (n == 1);
            @(negedge clk);
            n++;
        end
        mem_ack  = 1'b0;
        ioctl_rd = 1'b0;
        din      = ioctl_din;
    endtask

    // Drop the session for two cycles and raise it again; the model starts
    // a fresh session with zero count and a clear error flag.
    task automatic restart_session();
        @(negedge clk);
        ioctl_upload = 1'b0;
        repeat (2) @(negedge clk);
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk);
        exp_count = 0;
        exp_err   = 1'b0;
    endtask

    // Transaction-level reference: what the host must see for one read.
    task automatic model_read(input logic [24:0] addr, input logic [7:0] idx,
                              input int ack_delay, input logic [7:0] data,
                              output logic [7:0] e_din, output int e_wait,
                              output bit e_req);
        bit served;
        served = (idx == INDEX) && (addr < 25'(SIZE));
        if (served) begin
            e_req  = 1'b1;
            e_wait = (ack_delay < 0 || ack_delay >= TIMEOUT) ? TIMEOUT : ack_delay + 1;
            e_din  = (ack_delay < 0 || ack_delay >= TIMEOUT) ? FILL : data;
            if (ack_delay < 0 || ack_delay >= TIMEOUT) exp_err = 1'b1;
        end else begin
            e_req  = 1'b0;
            e_wait = 0;
            e_din  = FILL;
        end
        exp_count++;
        exp_din = e_din;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({ioctl_din, ioctl_wait, mem_req, upload_active, upload_err, mem_addr, upload_count}
            !== {FILL, 1'b0, 1'b0, 1'b0, 1'b0, {AW{1'b0}}, {(AW+1){1'b0}}}) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got din=%h wait=%b req=%b act=%b err=%b addr=%h cnt=%0d required din=ff all else 0",
                     ioctl_din, ioctl_wait, mem_req, upload_active, upload_err, mem_addr, upload_count);
        end
        reset_n = 1'b1;
        exp_count = 0;
        exp_err   = 1'b0;
        exp_din   = FILL;
    endtask

    task automatic test_normal();
        logic [7:0] din; int wc; bit rq; bit aok;
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (upload_active !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL upload_active: got %b required 1", upload_active);
        end
        read_txn(25'h00010, INDEX, 3, 8'h5A, 1'b0, din, wc, rq, aok);
        exp_count = 1;
        exp_din   = 8'h5A;
        vectors++;
        if (wc != 4) begin
            miscompares++;
            $display("[TB] FAIL normal_wait_cycles: got %0d required 4", wc);
        end
        vectors++;
        if (!(rq && aok)) begin
            miscompares++;
            $display("[TB] FAIL normal_mem_addr: got req_seen=%b addr_ok=%b required 1/1 at 00010", rq, aok);
        end
        vectors++;
        if (din !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL normal_din: got %h required 5a", din);
        end
        vectors++;
        if (upload_count !== 18'd1) begin
            miscompares++;
            $display("[TB] FAIL normal_count: got %0d required 1", upload_count);
        end
    endtask

    task automatic test_fill();
        logic [7:0] din; int wc; bit rq; bit aok;
        logic [24:0] addrs [3];
        logic [7:0]  idxs  [3];
        addrs[0] = 25'h0020000; idxs[0] = INDEX;
        addrs[1] = 25'h0000000; idxs[1] = 8'd3;
        addrs[2] = 25'h1000005; idxs[2] = INDEX;
        for (int i = 0; i < 3; i++) begin
            // Load a non-fill byte first so the FILL answer is observable.
            read_txn(25'h00005 + 25'(i), INDEX, 0, 8'h11 + 8'(i), 1'b0, din, wc, rq, aok);
            exp_count++;
            read_txn(addrs[i], idxs[i], 0, 8'h22, 1'b0, din, wc, rq, aok);
            exp_count++;
            vectors++;
            if (din !== FILL || wc != 0 || rq) begin
                miscompares++;
                $display("[TB] FAIL fill_%0d: got din=%h wait_cycles=%0d req=%b required ff/0/0", i, din, wc, rq);
            end
            vectors++;
            if (upload_count !== 18'(exp_count)) begin
                miscompares++;
                $display("[TB] FAIL fill_count_%0d: got %0d required %0d", i, upload_count, exp_count);
            end
        end
        exp_din = FILL;
    endtask

    task automatic test_timeout();
        logic [7:0] din; int wc; bit rq; bit aok;
        logic [7:0] e_din; int e_wait; bit e_req;
        model_read(25'h00100, INDEX, -1, 8'h00, e_din, e_wait, e_req);
        read_txn(25'h00100, INDEX, -1, 8'h00, 1'b0, din, wc, rq, aok);
        vectors++;
        if (wc != e_wait || din !== e_din || upload_err !== exp_err) begin
            miscompares++;
            $display("[TB] FAIL timeout: got wait_cycles=%0d din=%h err=%b required %0d/%h/%b",
                     wc, din, upload_err, e_wait, e_din, exp_err);
        end
        // Ack in the last REQ cycle must beat the timeout.
        model_read(25'h00101, INDEX, TIMEOUT - 1, 8'h6B, e_din, e_wait, e_req);
        read_txn(25'h00101, INDEX, TIMEOUT - 1, 8'h6B, 1'b0, din, wc, rq, aok);
        vectors++;
        if (wc != e_wait || din !== e_din || upload_count !== 18'(exp_count)) begin
            miscompares++;
            $display("[TB] FAIL ack_beats_timeout: got wait_cycles=%0d din=%h cnt=%0d required %0d/%h/%0d",
                     wc, din, upload_count, e_wait, e_din, exp_count);
        end
        restart_session();
        vectors++;
        if (upload_err !== 1'b0 || upload_count !== 18'd0) begin
            miscompares++;
            $display("[TB] FAIL session_clear: got err=%b cnt=%0d required 0/0", upload_err, upload_count);
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        ioctl_rd    = 1'b1;
        ioctl_addr  = 25'h00040;
        ioctl_index = INDEX;
        @(negedge clk);
        ioctl_rd = 1'b0;
        @(negedge clk);
        ioctl_upload = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b0 || ioctl_wait !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_release: got req=%b wait=%b required 0/0", mem_req, ioctl_wait);
        end
        repeat (2) @(negedge clk);
        mem_ack  = 1'b1;
        mem_data = 8'h3C;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (ioctl_din !== exp_din || upload_count !== 18'(exp_count) || mem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL late_ack_ignored: got din=%h cnt=%0d req=%b required %h/%0d/0",
                     ioctl_din, upload_count, mem_req, exp_din, exp_count);
        end
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk);
        exp_count = 0;
        exp_err   = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] din; int wc; bit rq; bit aok; int dly;
        logic [7:0] e_din; int e_wait; bit e_req;
        restart_session();
        for (int i = 0; i < 16; i++) begin
            dly = (i == 5) ? 3 : int'($urandom_range(0, 3));
            model_read(25'(i), INDEX, dly, 8'(i) ^ 8'hA5, e_din, e_wait, e_req);
            read_txn(25'(i), INDEX, dly, 8'(i) ^ 8'hA5, (i == 5), din, wc, rq, aok);
            vectors++;
            if (din !== e_din || wc != e_wait || !aok) begin
                miscompares++;
                $display("[TB] FAIL b2b_%0d: got din=%h wait_cycles=%0d addr_ok=%b required %h/%0d/1",
                         i, din, wc, aok, e_din, e_wait);
            end
        end
        vectors++;
        if (upload_count !== 18'd16) begin
            miscompares++;
            $display("[TB] FAIL b2b_count: got %0d required 16", upload_count);
        end
    endtask

    task automatic test_random();
        logic [7:0] din; int wc; bit rq; bit aok;
        logic [7:0] e_din; int e_wait; bit e_req;
        logic [24:0] addr; logic [7:0] idx; logic [7:0] data; int dly;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       addr = 25'(SIZE) + 25'($urandom_range(0, 3));
                1:       addr = 25'($urandom) | 25'h1000000;
                default: addr = 25'($urandom_range(0, SIZE - 1));
            endcase
            idx  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : INDEX;
            data = 8'($urandom);
            dly  = int'($urandom_range(0, 6));
            model_read(addr, idx, dly, data, e_din, e_wait, e_req);
            read_txn(addr, idx, dly, data, 1'b0, din, wc, rq, aok);
            vectors++;
            if (din !== e_din || wc != e_wait || rq != e_req || !aok
                || upload_count !== 18'(exp_count)) begin
                miscompares++;
                $display("[TB] FAIL random_%0d addr=%h idx=%h: got din=%h wait=%0d req=%b aok=%b cnt=%0d required %h/%0d/%b/1/%0d",
                         i, addr, idx, din, wc, rq, aok, upload_count, e_din, e_wait, e_req, exp_count);
            end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] din; int wc; bit rq; bit aok;
        restart_session();
        for (int i = 0; i < 20; i++) begin
            read_txn(25'h0020000, INDEX, 0, 8'h00, 1'b0, din, wc, rq, aok);
            exp_count++;
        end
        vectors++;
        if (s_count !== 4'hF) begin
            miscompares++;
            $display("[TB] FAIL count_saturate: got %0d required 15", s_count);
        end
        vectors++;
        if (upload_count !== 18'(exp_count)) begin
            miscompares++;
            $display("[TB] FAIL count_20: got %0d required %0d", upload_count, exp_count);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] din; int wc; bit rq; bit aok;
        @(negedge clk);
        ioctl_rd    = 1'b1;
        ioctl_addr  = 25'h00200;
        ioctl_index = INDEX;
        @(negedge clk);
        ioctl_rd = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || ioctl_wait !== 1'b0 || ioctl_din !== FILL || upload_count !== 18'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got req=%b wait=%b din=%h cnt=%0d required 0/0/ff/0",
                     mem_req, ioctl_wait, ioctl_din, upload_count);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        exp_count = 0;
        exp_err   = 1'b0;
        read_txn(25'h01ABC, INDEX, 1, 8'h77, 1'b0, din, wc, rq, aok);
        vectors++;
        if (din !== 8'h77 || wc != 2 || !aok || upload_count !== 18'd1) begin
            miscompares++;
            $display("[TB] FAIL after_reset_read: got din=%h wait=%0d aok=%b cnt=%0d required 77/2/1/1",
                     din, wc, aok, upload_count);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        ioctl_index  = '0;
        mem_ack      = 1'b0;
        mem_data     = '0;
        test_reset();
        test_normal();
        test_fill();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_random();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
